// File: rtl/karatsuba_mul_arbiter_if.sv
// Request/response bus between the client datapaths and the shared
// Karatsuba multiplier arbiter. Requester i owns bit i of req_valid/req_ready
// and slice i (N bits) of req_a/req_b. The arbiter uses the slave modport and
// the clients (or a bench) use the master modport.
interface karatsuba_mul_arbiter_if #(
  parameter int N       = 32,
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ*N-1:0] req_a;
  logic [NUM_REQ*N-1:0] req_b;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [ID_W-1:0]      rsp_id;
  logic [2*N-1:0]       rsp_z;

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_z
  );

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_z
  );
endinterface

// File: rtl/karatsuba_mul_arbiter.sv
// Round-robin arbiter that time-shares one iterative Karatsuba multiplier
// among NUM_REQ requesters. Each accepted operation goes through
// IDLE -> CLEAR -> RUN -> RESP: the multiplier is cleared for one cycle,
// enabled for MUL_LATENCY cycles, and its product is captured and returned
// with the requester index on a valid/ready response channel. Only one
// operation is in flight at a time.
//
// Optional feature: define KMUL_ARB_ZERO_BYPASS_EN to answer operations with
// a zero operand directly (RESP in the cycle after the handshake, rsp_z = 0),
// without pulsing the multiplier. Without the macro every operation takes the
// full CLEAR/RUN path.
module karatsuba_mul_arbiter #(
  parameter int N           = 32,
  parameter int NUM_REQ     = 4,
  parameter int MUL_LATENCY = 5,
  parameter int ID_W        = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  karatsuba_mul_arbiter_if.slave bus,
  output logic                   o_mul_rst,
  output logic                   o_mul_enable,
  output logic [N-1:0]           o_mul_a,
  output logic [N-1:0]           o_mul_b,
  input  logic [2*N-1:0]         i_mul_c
);

  localparam int CNT_W = $clog2(MUL_LATENCY + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_RESP
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  logic [ID_W-1:0]       r_ptr;
  logic [ID_W-1:0]       r_id;
  logic [N-1:0]          r_a;
  logic [N-1:0]          r_b;
  logic [2*N-1:0]        r_z;
  logic [CNT_W-1:0]      r_cnt;

  logic                  w_found;
  logic [ID_W-1:0]       w_gnt_idx;
  logic [N-1:0]          w_a;
  logic [N-1:0]          w_b;
  logic                  w_zero;
  logic                  w_hs;
  logic [NUM_REQ-1:0]    w_req_ready;
  logic                  w_run_last;

  // Round-robin search: first valid requester at or after the pointer, wrapping.
  always_comb begin
    logic [ID_W-1:0] cand;
    w_found   = 1'b0;
    w_gnt_idx = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = ID_W'((int'(r_ptr) + k) % NUM_REQ);
      if (!w_found && bus.req_valid[cand]) begin
        w_found   = 1'b1;
        w_gnt_idx = cand;
      end
    end
  end

  // Select the granted requester's operand slices.
  always_comb begin
    w_a = '0;
    w_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == w_gnt_idx) begin
        w_a = bus.req_a[i*N +: N];
        w_b = bus.req_b[i*N +: N];
      end
    end
`ifdef KMUL_ARB_ZERO_BYPASS_EN
    w_zero = (w_a == '0) || (w_b == '0);
`else
    w_zero = 1'b0;
`endif
  end

  assign w_run_last = (r_state == S_RUN) && (r_cnt == '0);

  // Next-state logic and the combinational one-hot grant (only offered in IDLE).
  always_comb begin
    w_state_nxt = r_state;
    w_req_ready = '0;
    w_hs        = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_found && !rst) begin
          w_req_ready[w_gnt_idx] = 1'b1;
          w_hs                   = 1'b1;
          w_state_nxt            = w_zero ? S_RESP : S_CLEAR;
        end
      end
      S_CLEAR: w_state_nxt = S_RUN;
      S_RUN: begin
        if (w_run_last) w_state_nxt = S_RESP;
      end
      S_RESP: begin
        if (bus.rsp_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Operand/ID latch on handshake, RR pointer, RUN down-counter, product capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
      r_id  <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_z   <= '0;
      r_cnt <= '0;
    end else begin
      if (w_hs) begin
        r_a   <= w_a;
        r_b   <= w_b;
        r_id  <= w_gnt_idx;
        r_ptr <= (w_gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;
        if (w_zero) r_z <= '0;
      end
      if (r_state == S_CLEAR)                r_cnt <= CNT_W'(MUL_LATENCY - 1);
      else if (r_state == S_RUN && !w_run_last) r_cnt <= r_cnt - 1'b1;
      if (w_run_last) r_z <= i_mul_c;
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.rsp_valid = (r_state == S_RESP);
  assign bus.rsp_id    = r_id;
  assign bus.rsp_z     = r_z;

  // The multiplier is held in reset with the arbiter and cleared in CLEAR.
  assign o_mul_rst    = rst || (r_state == S_CLEAR);
  assign o_mul_enable = (r_state == S_RUN);
  assign o_mul_a      = r_a;
  assign o_mul_b      = r_b;

endmodule

// File: tb/tb_karatsuba_mul_arbiter.sv
// Bench for karatsuba_mul_arbiter with a behavioural multiplier that only
// presents the true product after MUL_LATENCY-1 enabled cycles since its
// last clear, so an early capture returns a poison value.
module tb_karatsuba_mul_arbiter;
  localparam int N = 32;
  localparam int NUM_REQ = 4;
  localparam int MUL_LATENCY = 5;
  localparam int ID_W = 2;
`ifdef KMUL_ARB_ZERO_BYPASS_EN
  localparam int LAT_ZERO = 1;
  localparam int EN_ZERO  = 0;
`else
  localparam int LAT_ZERO = 7;
  localparam int EN_ZERO  = 5;
`endif

  logic clk = 1'b0;
  logic rst;
  logic mul_rst, mul_enable;
  logic [N-1:0] mul_a, mul_b;
  logic [2*N-1:0] mul_c;

  karatsuba_mul_arbiter_if #(.N(N), .NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

  karatsuba_mul_arbiter #(.N(N), .NUM_REQ(NUM_REQ), .MUL_LATENCY(MUL_LATENCY), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .o_mul_rst(mul_rst), .o_mul_enable(mul_enable),
    .o_mul_a(mul_a), .o_mul_b(mul_b), .i_mul_c(mul_c)
  );

  always #5 clk = ~clk;

  int mcnt = 0;
  int en_cnt = 0;
  always @(posedge clk) begin
    if (mul_rst) mcnt <= 0;
    else if (mul_enable) mcnt <= mcnt + 1;
    if (mul_enable) en_cnt <= en_cnt + 1;
  end
  assign mul_c = (mcnt >= MUL_LATENCY - 1) ? (64'(mul_a) * 64'(mul_b)) : 64'hDEAD_BEEF_DEAD_BEEF;

  typedef struct {
    logic [ID_W-1:0] id;
    logic [2*N-1:0]  z;
  } exp_t;
  exp_t sb_q[$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Response monitor: pops the scoreboard on every accepted response.
  always @(negedge clk) begin
    if (!rst && bus.rsp_valid && bus.rsp_ready) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_rsp: got id=%0d z=0x%0h expected no response", bus.rsp_id, bus.rsp_z);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("rsp_id", 64'(bus.rsp_id), 64'(e.id));
        check("rsp_z", bus.rsp_z, e.z);
      end
    end
  end

  task automatic do_req(input int id, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [2*N-1:0] expz);
    bit ok;
    ok = 1'b0;
    bus.req_valid[id] = 1'b1;
    bus.req_a[id*N +: N] = a;
    bus.req_b[id*N +: N] = b;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (bus.req_ready[id]) begin
        sb_q.push_back('{id: ID_W'(id), z: expz});
        @(posedge clk);
        #1;
        bus.req_valid[id] = 1'b0;
        bus.req_a[id*N +: N] = ~a;
        bus.req_b[id*N +: N] = ~b;
        ok = 1'b1;
      end
    end
    if (!ok) begin
      bus.req_valid[id] = 1'b0;
      check("grant_timeout", 64'd0, 64'd1);
    end
  endtask

  task automatic wait_rsp(output int cyc);
    cyc = 1;
    while (!bus.rsp_valid && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic wait_done();
    int i;
    i = 0;
    while (sb_q.size() != 0 && i < 300) begin
      @(posedge clk);
      #1;
      i++;
    end
    check("drain_timeout", 64'(sb_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_req_ready"}, 64'(bus.req_ready), 64'd0);
    check({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd0);
    check({tag, "_rsp_id"}, 64'(bus.rsp_id), 64'd0);
    check({tag, "_rsp_z"}, bus.rsp_z, 64'd0);
    check({tag, "_mul_enable"}, 64'(mul_enable), 64'd0);
    check({tag, "_mul_a"}, 64'(mul_a), 64'd0);
    check({tag, "_mul_b"}, 64'(mul_b), 64'd0);
    check({tag, "_mul_rst"}, 64'(mul_rst), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    int en0;
    int gcount;
    int gid;
    logic [63:0] exp_rr [0:3];
    exp_rr[0] = 64'd0;
    exp_rr[1] = 64'd12;
    exp_rr[2] = 64'd24;
    exp_rr[3] = 64'd36;

    rst = 1'b1;
    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    bus.req_valid = 4'hF;
    #1;
    check_reset_vals("rst");
    bus.req_valid = '0;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single op with latency and enable-cycle count
    en0 = en_cnt;
    do_req(0, 32'd10, 32'd12, 64'd120);
    wait_rsp(cyc);
    check("lat_single", 64'(cyc), 64'd7);
    wait_done();
    check("en_cycles_single", 64'(en_cnt - en0), 64'd5);

    // Full-width product on requester 2
    do_req(2, 32'hFFFF_FFFF, 32'h0000_00FF, 64'h0000_00FE_FFFF_FF01);
    wait_rsp(cyc);
    check("lat_wide", 64'(cyc), 64'd7);
    wait_done();

    // Zero operand
    en0 = en_cnt;
    do_req(3, 32'd0, 32'd99, 64'd0);
    wait_rsp(cyc);
    check("lat_zero", 64'(cyc), 64'(LAT_ZERO));
    wait_done();
    check("en_cycles_zero", 64'(en_cnt - en0), 64'(EN_ZERO));

    // Backpressure: response held, no new grants
    bus.rsp_ready = 1'b0;
    do_req(1, 32'd1000, 32'd2000, 64'd2000000);
    wait_rsp(cyc);
    check("lat_bp", 64'(cyc), 64'd7);
    bus.req_valid[3] = 1'b1;
    bus.req_a[3*N +: N] = 32'd7;
    bus.req_b[3*N +: N] = 32'd6;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      check("bp_rsp_valid", 64'(bus.rsp_valid), 64'd1);
      check("bp_rsp_id", 64'(bus.rsp_id), 64'd1);
      check("bp_rsp_z", bus.rsp_z, 64'd2000000);
      check("bp_req_ready", 64'(bus.req_ready), 64'd0);
    end
    bus.req_valid[3] = 1'b0;
    bus.rsp_ready = 1'b1;
    wait_done();

    // Reset in the third RUN cycle drops the op
    do_req(0, 32'd5, 32'd5, 64'd25);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("mid_run_enable", 64'(mul_enable), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_vals("midrst");
    sb_q.delete();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("post_rst_no_rsp", 64'(bus.rsp_valid), 64'd0);
    end
    do_req(1, 32'd3, 32'd4, 64'd12);
    wait_done();

    // Round-robin with all requesters valid, pointer freshly reset
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_a[i*N +: N] = N'(i);
      bus.req_b[i*N +: N] = 32'd12;
    end
    bus.req_valid = 4'hF;
    gcount = 0;
    for (int t = 0; t < 400 && gcount < 5; t++) begin
      @(negedge clk);
      if (bus.req_ready != '0) begin
        gid = 0;
        for (int k = 0; k < NUM_REQ; k++) if (bus.req_ready[k]) gid = k;
        check("rr_onehot", 64'($countones(bus.req_ready)), 64'd1);
        check("rr_order", 64'(gid), 64'(gcount % 4));
        sb_q.push_back('{id: ID_W'(gid), z: exp_rr[gid]});
        gcount++;
        @(posedge clk);
        #1;
        if (gcount == 5) bus.req_valid = '0;
      end
    end
    check("rr_grants", 64'(gcount), 64'd5);
    bus.req_valid = '0;
    wait_done();

    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
